// File: rtl/pow_pkg.sv
// Shared types and defaults for the sequential n**exp engine.
// Holds the FSM state encoding and the default operand/exponent widths.
package pow_pkg;

   localparam int DEF_WIDTH = 18;
   localparam int DEF_EXP_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pow_mul_wide.sv
// Full-width unsigned multiplier: W x W -> 2W product, purely combinational.
module pow_mul_wide #(
   parameter int W = 18
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/pow_n_seq.sv
// Sequential n**exp mod 2**WIDTH using right-to-left square-and-multiply,
// one exponent bit per cycle, with exact overflow detection.
module pow_n_seq
   import pow_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int EXP_W = DEF_EXP_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] n,
   input  logic [EXP_W-1:0] exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] n_pow,
   output logic             overflow,
   output state_t           dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; ready/valid depend only on registered state, and the result is held
   // stable while out_valid && !out_ready.

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   base_q, base_d;
   logic [EXP_W-1:0]   e_q, e_d;
   logic               base_ovf_q, base_ovf_d;
   logic               ovf_q, ovf_d;
   logic [2*WIDTH-1:0] prod_ab;
   logic [2*WIDTH-1:0] prod_bb;

   pow_mul_wide #(.W(WIDTH)) u_mul_acc (.a(acc_q),  .b(base_q), .p(prod_ab));
   pow_mul_wide #(.W(WIDTH)) u_mul_sq  (.a(base_q), .b(base_q), .p(prod_bb));

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      base_d     = base_q;
      e_d        = e_q;
      base_ovf_d = base_ovf_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d      = WIDTH'(1);
               base_d     = n;
               e_d        = exp;
               base_ovf_d = 1'b0;
               ovf_d      = 1'b0;
               state_d    = (exp != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            base_d     = prod_bb[WIDTH-1:0];
            base_ovf_d = base_ovf_q | (|prod_bb[2*WIDTH-1:WIDTH]);
            e_d        = e_q >> 1;
            // A truncated base means the true partial power already exceeds 2**WIDTH.
            if (e_q[0]) begin
               acc_d = prod_ab[WIDTH-1:0];
               ovf_d = ovf_q | (|prod_ab[2*WIDTH-1:WIDTH]) | base_ovf_q;
            end
            if ((e_q >> 1) == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         base_ovf_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         base_ovf_q <= base_ovf_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clock) begin
      base_q <= base_d;
      e_q    <= e_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign n_pow     = acc_q;
   assign overflow  = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pow_n_seq.sv
// Bench for pow_n_seq: two instances (18/4 and 8/3) checked by a scoreboard
// fed from a repeated-multiplication reference model.
module tb_pow_n_seq;
   import pow_pkg::*;

   localparam int W0 = 18;
   localparam int E0 = 4;
   localparam int W1 = 8;
   localparam int E1 = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    in_valid, in_ready, out_valid, out_ready, ovf;
   logic [W0-1:0] n0, pow0;
   logic [E0-1:0] e0;
   logic [W1-1:0] n1, pow1;
   logic [E1-1:0] e1;
   state_t        st0, st1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // entries are {overflow, value}
   logic [W0:0] exp_q0[$];
   logic [W0:0] exp_q1[$];
   int          lat_q0[$], lat_q1[$];
   int          acc_q0[$], acc_q1[$];
   bit          seen[2];
   bit          rdy_rand[2];
   bit          rdy_val[2];

   pow_n_seq #(.WIDTH(W0), .EXP_W(E0)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .n(n0), .exp(e0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .n_pow(pow0), .overflow(ovf[0]), .dbg_state(st0));

   pow_n_seq #(.WIDTH(W1), .EXP_W(E1)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .n(n1), .exp(e1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .n_pow(pow1), .overflow(ovf[1]), .dbg_state(st1));

   // ---------------- clock / reset helpers ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W0:0] model(input int unsigned nv, input int unsigned ev, input int w);
      longint unsigned lim = 64'd1 << w;
      longint unsigned base = longint'(nv) & (lim - 1);
      longint unsigned val = 1;
      bit o = 1'b0;
      for (int i = 0; i < int'(ev); i++) begin
         val = val * base;
         if (val >= lim) begin
            o = 1'b1;
            val = val % lim;
         end
      end
      return {o, val[W0-1:0]};
   endfunction

   function automatic int bitlen(input int unsigned v);
      int b = 0;
      while (v != 0) begin
         b++;
         v = v >> 1;
      end
      return b;
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input int d, input int unsigned nv, input int unsigned ev);
      int budget = 0;
      logic [W0:0] r = model(nv, ev, (d == 0) ? W0 : W1);
      if (d == 0) begin exp_q0.push_back(r); lat_q0.push_back(1 + bitlen(ev)); end
      else        begin exp_q1.push_back(r); lat_q1.push_back(1 + bitlen(ev)); end
      @(negedge clock);
      if (d == 0) begin n0 = W0'(nv); e0 = E0'(ev); end
      else        begin n1 = W1'(nv); e1 = E1'(ev); end
      in_valid[d] = 1'b1;
      while (!in_ready[d] && budget < 300) begin
         @(negedge clock);
         budget++;
      end
      if (!in_ready[d]) begin
         chk("accept_timeout", 64'd0, 64'd1);
         in_valid[d] = 1'b0;
         return;
      end
      if (d == 0) acc_q0.push_back(cyc);
      else        acc_q1.push_back(cyc);
      @(posedge clock);
      #1 in_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int budget = 0;
      while (((d == 0) ? exp_q0.size() : exp_q1.size()) > 0 && budget < 3000) begin
         @(negedge clock);
         budget++;
      end
      chk("drain_timeout", (d == 0) ? exp_q0.size() : exp_q1.size(), 64'd0);
   endtask

   initial begin
      out_ready = '0;
      forever begin
         @(posedge clock);
         #1;
         for (int d = 0; d < 2; d++)
            out_ready[d] = rdy_rand[d] ? 1'($urandom_range(0, 1)) : rdy_val[d];
      end
   end

   // ---------------- scoreboard monitors ----------------
   always @(negedge clock) begin
      if (!reset && out_valid[0]) begin
         if (exp_q0.size() == 0) chk("unexpected_out0", 64'd1, 64'd0);
         else begin
            if (!seen[0] && acc_q0.size() > 0) begin
               seen[0] = 1'b1;
               chk("latency0", cyc - acc_q0[0], lat_q0[0]);
            end
            chk("n_pow0", pow0, exp_q0[0][W0-1:0]);
            chk("ovf0", ovf[0], exp_q0[0][W0]);
            if (out_ready[0]) begin
               void'(exp_q0.pop_front());
               void'(lat_q0.pop_front());
               if (acc_q0.size() > 0) void'(acc_q0.pop_front());
               seen[0] = 1'b0;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && out_valid[1]) begin
         if (exp_q1.size() == 0) chk("unexpected_out1", 64'd1, 64'd0);
         else begin
            if (!seen[1] && acc_q1.size() > 0) begin
               seen[1] = 1'b1;
               chk("latency1", cyc - acc_q1[0], lat_q1[0]);
            end
            chk("n_pow1", pow1, exp_q1[0][W1-1:0]);
            chk("ovf1", ovf[1], exp_q1[0][W0]);
            if (out_ready[1]) begin
               void'(exp_q1.pop_front());
               void'(lat_q1.pop_front());
               if (acc_q1.size() > 0) void'(acc_q1.pop_front());
               seen[1] = 1'b0;
            end
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int budget;
      reset = 1'b1;
      in_valid = '0;
      n0 = '0; e0 = '0; n1 = '0; e1 = '0;
      rdy_rand = '{1'b0, 1'b0};
      rdy_val  = '{1'b1, 1'b1};
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_in_ready", in_ready, 2'b11);
      chk("rst_out_valid", out_valid, 2'b00);
      chk("rst_n_pow0", pow0, 0);
      chk("rst_n_pow1", pow1, 0);
      chk("rst_ovf", ovf, 2'b00);
      chk("rst_state0", st0, IDLE);

      // directed corner cases
      issue(0, 3, 5);  issue(0, 7, 0);  issue(0, 0, 0);  issue(0, 0, 9);
      issue(0, 7, 7);  issue(0, 4, 9);  issue(0, 2, 15); issue(0, 262143, 15);
      drain(0);
      issue(1, 3, 5);  issue(1, 2, 7);  issue(1, 3, 6);  issue(1, 255, 7);
      issue(1, 16, 2); issue(1, 0, 0);
      drain(1);

      // consumer stall: result held, new requests ignored
      rdy_val[0] = 1'b0;
      issue(0, 3, 5);
      budget = 0;
      while (!out_valid[0] && budget < 50) begin
         @(negedge clock);
         budget++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("stall_out_valid", out_valid[0], 1'b1);
         chk("stall_in_ready", in_ready[0], 1'b0);
         if (i == 4) begin n0 = 9; e0 = 2; in_valid[0] = 1'b1; end
         if (i == 5) in_valid[0] = 1'b0;
         @(negedge clock);
      end
      rdy_val[0] = 1'b1;
      drain(0);

      // reset mid-operation discards the result
      issue(0, 5, 15);
      @(posedge clock);
      #1 reset = 1'b1;
      exp_q0.delete(); lat_q0.delete(); acc_q0.delete(); seen[0] = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
      chk("midrst_state0", st0, IDLE);
      chk("midrst_out_valid0", out_valid[0], 1'b0);
      chk("midrst_in_ready0", in_ready[0], 1'b1);
      issue(0, 2, 3);
      drain(0);

      // random back-to-back with random backpressure
      rdy_rand = '{1'b1, 1'b1};
      fork
         for (int i = 0; i < 80; i++)
            issue(0, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, (1 << W0) - 1),
                  $urandom_range(0, (1 << E0) - 1));
         for (int j = 0; j < 80; j++)
            issue(1, $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, (1 << W1) - 1),
                  $urandom_range(0, (1 << E1) - 1));
      join
      drain(0);
      drain(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pow_n_seq.md
POW_N_SEQ -- requirements
Module: pow_n_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, the width of operand and result.
REQ-002 The block SHALL have parameter EXP_W, default 4, the width of the runtime exponent.
REQ-003 Port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port in_valid  in  1  n/exp valid.
REQ-006 Port in_ready  out  1  block accepts a new operation.
REQ-007 Port n  in  WIDTH  base, unsigned.
REQ-008 Port exp  in  EXP_W  exponent, unsigned.
REQ-009 Port out_valid  out  1  result valid.
REQ-010 Port out_ready  in  1  consumer accepts result.
REQ-011 Port n_pow  out  WIDTH  n**exp mod 2**WIDTH.
REQ-012 Port overflow  out  1  true n**exp >= 2**WIDTH.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept SHALL be the edge with in_valid && in_ready: load acc=1, base=n, e=exp, base_ovf=0, overflow=0; next state RUN if exp!=0, else DONE.
REQ-015 In RUN, each cycle SHALL apply one right-to-left square-and-multiply step: if e[0], acc<=acc*base (low WIDTH bits); base<=base*base (low WIDTH bits); e<=e>>1.
REQ-016 RUN SHALL go to DONE on the edge where e>>1 == 0; otherwise it stays in RUN.
REQ-017 Latency from the accept edge to the first cycle with out_valid high SHALL be 1+bitlen(exp) cycles, with bitlen(0)=0; exp=0 gives 1, exp=15 gives 5.
REQ-018 Overflow tracking: base_ovf |= (upper WIDTH bits of base*base != 0); on a step with e[0]=1, overflow |= (upper WIDTH bits of acc*base != 0) || base_ovf.
REQ-019 0**0 SHALL give 1; 0**k (k>0) SHALL give 0, overflow=0.
REQ-020 n_pow SHALL equal acc, and n_pow/overflow SHALL be held stable while out_valid && !out_ready.
REQ-021 The DONE->IDLE transition SHALL occur on the out_valid && out_ready edge; the earliest next accept is the following edge (no same-cycle turnaround).
REQ-022 in_valid SHALL be ignored outside IDLE; n/exp are sampled only at the accept edge.

Reset
REQ-023 Reset SHALL put the FSM in IDLE, with out_valid=0, in_ready=1, n_pow=0, overflow=0, base_ovf=0.
REQ-024 Reset asserted in RUN or DONE SHALL discard the operation, and no out_valid pulse may follow it.
REQ-025 Datapath registers other than those listed SHALL need no reset.

Structure
REQ-026 Shared package pow_pkg SHALL hold the state type (IDLE/RUN/DONE) and the default WIDTH and EXP_W constants.
REQ-027 A single sub-module pow_mul_wide (WIDTH x WIDTH -> 2*WIDTH unsigned product) SHALL be instantiated twice, once for acc*base and once for base*base.
REQ-028 The block SHALL contain no combinational path from in_valid or out_ready to in_ready or out_valid.

Verification
REQ-029 n=3, exp=5, out_ready=1 -> n_pow=243, overflow=0, out_valid 4 cycles after accept.
REQ-030 n=7, exp=0 -> n_pow=1 after 1 cycle; n=0, exp=0 -> 1; n=0, exp=9 -> 0, overflow=0.
REQ-031 n=7, exp=7 -> n_pow=37111, overflow=1; n=4, exp=9 -> n_pow=0, overflow=1; n=2, exp=15 -> 32768, overflow=0.
REQ-032 n=3, exp=5 with out_ready held low 10 cycles -> out_valid and n_pow=243 held; in_ready=0 throughout; an in_valid pulse in that window is ignored.
REQ-033 Reset asserted 2 cycles after accepting n=5, exp=15 -> next cycle state IDLE, out_valid=0; then n=2, exp=3 -> 8.
REQ-034 Back-to-back random n and exp with random out_ready, against a scoreboard model of n**exp mod 2**WIDTH plus exact overflow, for WIDTH=18/EXP_W=4 and WIDTH=8/EXP_W=3.
